// File: rtl/carregador_vetores_pkg.sv
// Shared types and default sizing for the dot-product operand loader.
package carregador_vetores_pkg;

  localparam int unsigned N_DEF      = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RES_W_DEF  = 64;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic signed [DATA_W_DEF-1:0] elem_t;

endpackage

// File: rtl/carregador_vetores.sv
// Loads 2*N stream elements into operand registers, kicks produto_escalar,
// and hands the captured result back over a valid/ready handshake.
module carregador_vetores
  import carregador_vetores_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_clear,
  output logic [N*DATA_W-1:0] o_a,
  output logic [N*DATA_W-1:0] o_b,
  output logic                o_start,
  input  logic                i_done,
  input  logic [RES_W-1:0]    i_result,
  output logic                o_res_valid,
  output logic [RES_W-1:0]    o_result,
  input  logic                i_res_ready,
  output logic                o_busy
);

  localparam int unsigned CNT_W = $clog2(2 * N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             drop;

  // Control FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD;
      cnt         <= '0;
      drop        <= 1'b0;
      o_a         <= '0;
      o_b         <= '0;
      o_result    <= '0;
      o_ready     <= 1'b1;
      o_start     <= 1'b0;
      o_res_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_start <= 1'b0;
      case (state)
        LOAD: begin
          // A clear wins over an element offered in the same cycle.
          if (i_clear) begin
            cnt <= '0;
          end else if (i_valid) begin
            for (int k = 0; k < int'(N); k++) begin
              if (cnt == CNT_W'(k))     o_a[k*DATA_W +: DATA_W] <= i_data;
              if (cnt == CNT_W'(k + N)) o_b[k*DATA_W +: DATA_W] <= i_data;
            end
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              state   <= FIRE;
              o_ready <= 1'b0;
              o_start <= 1'b1;
              o_busy  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FIRE: begin
          state <= WAIT;
          if (i_clear) drop <= 1'b1;
        end
        WAIT: begin
          if (i_done) begin
            o_busy <= 1'b0;
            drop   <= 1'b0;
            // The downstream op cannot be aborted, so a flushed run is absorbed here.
            if (drop || i_clear) begin
              state   <= LOAD;
              o_ready <= 1'b1;
            end else begin
              o_result    <= i_result;
              state       <= OUT;
              o_res_valid <= 1'b1;
            end
          end else if (i_clear) begin
            drop <= 1'b1;
          end
        end
        OUT: begin
          if (i_clear || i_res_ready) begin
            state       <= LOAD;
            o_res_valid <= 1'b0;
            o_ready     <= 1'b1;
          end
        end
        default: begin
          state       <= LOAD;
          o_ready     <= 1'b1;
          o_res_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_vetores.sv
// Self-checking bench for carregador_vetores with a behavioural produto_escalar stand-in.
module tb_carregador_vetores;
  import carregador_vetores_pkg::*;

  localparam int unsigned N  = N_DEF;
  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned RW = RES_W_DEF;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          i_clear;
  logic [N*DW-1:0] o_a;
  logic [N*DW-1:0] o_b;
  logic          o_start;
  logic          i_done;
  logic [RW-1:0] i_result;
  logic          o_res_valid;
  logic [RW-1:0] o_result;
  logic          i_res_ready;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  elem_t va [N];
  elem_t vb [N];

  carregador_vetores #(.N(N), .DATA_W(DW), .RES_W(RW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .i_clear(i_clear), .o_a(o_a), .o_b(o_b), .o_start(o_start), .i_done(i_done),
    .i_result(i_result), .o_res_valid(o_res_valid), .o_result(o_result),
    .i_res_ready(i_res_ready), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_start === 1'b1) starts++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint ref_dot();
    longint s = 0;
    for (int k = 0; k < int'(N); k++) s += longint'(va[k]) * longint'(vb[k]);
    return s;
  endfunction

  // Stand-in for produto_escalar: answers each start after a random latency.
  initial begin
    longint dot;
    elem_t  ea, eb;
    int     lat;
    bit     abort;
    i_done   = 1'b0;
    i_result = '0;
    forever begin
      @(negedge clk);
      if (o_start === 1'b1) begin
        dot = 0;
        for (int k = 0; k < int'(N); k++) begin
          ea = o_a[k*DW +: DW];
          eb = o_b[k*DW +: DW];
          dot += longint'(ea) * longint'(eb);
        end
        lat   = int'($urandom_range(2, 5));
        abort = 1'b0;
        for (int j = 0; j < lat; j++) begin
          @(negedge clk);
          if (rst) abort = 1'b1;
        end
        if (!abort) begin
          i_result = RW'(dot);
          i_done   = 1'b1;
          @(negedge clk);
          i_done   = 1'b0;
        end
      end
    end
  end

  task automatic set_basic();
    for (int k = 0; k < int'(N); k++) begin
      va[k] = elem_t'(k);
      vb[k] = elem_t'(int'(N) - k);
    end
  endtask

  task automatic set_random();
    for (int k = 0; k < int'(N); k++) begin
      va[k] = elem_t'($urandom);
      vb[k] = elem_t'($urandom);
    end
  endtask

  // Streams A then B; returns at the negedge of the cycle after the final accept.
  task automatic load_vec(input bit bubbles);
    int k = 0;
    int guard = 0;
    while (k < 2 * int'(N) && guard < 2000) begin
      @(negedge clk);
      i_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_data  = (k < int'(N)) ? va[k] : vb[k - int'(N)];
      if (i_valid && o_ready) k++;
      guard++;
    end
    if (k < 2 * int'(N)) check("load_timeout", 64'(k), 64'(2 * N));
    @(negedge clk);
    i_valid = 1'b0;
    check("start_latency", 64'(o_start), 64'd1);
    check("busy_in_fire", 64'(o_busy), 64'd1);
    check("ready_in_fire", 64'(o_ready), 64'd0);
  endtask

  task automatic get_result(input longint exp, input int hold);
    int g = 0;
    i_res_ready = (hold == 0);
    while (!o_res_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("res_valid_seen", 64'(o_res_valid), 64'd1);
    check("result", o_result, 64'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(o_res_valid), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
      check("hold_result", o_result, 64'(exp));
    end
    i_res_ready = 1'b1;
    @(negedge clk);
    check("valid_drop", 64'(o_res_valid), 64'd0);
    check("ready_back", 64'(o_ready), 64'd1);
  endtask

  initial begin
    int  s0;
    bit  saw, vsee, rdy;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_clear = 1'b0; i_res_ready = 1'b0;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_start", 64'(o_start), 64'd0);
    check("rst_valid", 64'(o_res_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_a", o_a, 64'd0);
    check("rst_result", o_result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic vectors
    set_basic();
    s0 = starts;
    load_vec(1'b0);
    get_result(ref_dot(), 0);
    #1 check("basic_one_start", 64'(starts - s0), 64'd1);
    check("basic_ref", 64'(ref_dot()), 64'd84);

    // Extremes
    for (int k = 0; k < int'(N); k++) begin va[k] = -128; vb[k] = -128; end
    load_vec(1'b0);
    get_result(131072, 0);
    for (int k = 0; k < int'(N); k++) begin va[k] = -128; vb[k] = 127; end
    load_vec(1'b0);
    get_result(-130048, 0);

    // Bubbles and result backpressure
    set_basic();
    load_vec(1'b1);
    get_result(84, 5);

    // Clear mid-load
    repeat (5) begin
      @(negedge clk);
      i_valid = 1'b1; i_data = 8'h7F;
    end
    @(negedge clk);
    i_clear = 1'b1;
    check("clear_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    i_clear = 1'b0; i_valid = 1'b0;
    s0 = starts;
    load_vec(1'b0);
    get_result(84, 0);
    #1 check("clear_one_start", 64'(starts - s0), 64'd1);

    // Clear while waiting for done
    load_vec(1'b0);
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    saw = 1'b0; vsee = 1'b0; rdy = 1'b0;
    #1;
    for (int g = 0; g < 50; g++) begin
      if (o_res_valid) vsee = 1'b1;
      if (saw) begin
        rdy = o_ready;
        break;
      end
      if (i_done) saw = 1'b1;
      @(negedge clk);
      #1;
    end
    check("drop_done_seen", 64'(saw), 64'd1);
    check("drop_no_valid", 64'(vsee), 64'd0);
    check("drop_ready", 64'(rdy), 64'd1);
    check("drop_result_kept", o_result, 64'd84);
    set_random();
    load_vec(1'b1);
    get_result(ref_dot(), 0);

    // Asynchronous reset while waiting
    set_random();
    load_vec(1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(o_busy), 64'd0);
    check("arst_start", 64'(o_start), 64'd0);
    check("arst_valid", 64'(o_res_valid), 64'd0);
    check("arst_ready", 64'(o_ready), 64'd1);
    check("arst_a", o_a, 64'd0);
    check("arst_b", o_b, 64'd0);
    check("arst_result", o_result, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_basic();
    load_vec(1'b0);
    get_result(84, 0);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      set_random();
      load_vec(1'($urandom_range(0, 1)));
      get_result(ref_dot(), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
